seq_game_controller: RTL and testbench

//   Parametrised control unit for the memory-sequence game. Owns the position counter,

---
 rtl/seq_game_if.sv | 33 +++
 rtl/seq_game_controller.sv | 193 +++++++++++++++++++
 tb/tb_seq_game_controller.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_game_if.sv
// Signal bundle between the memory-sequence game controller and its datapath/environment.
// The master side is the controller; the slave side drives player and datapath inputs.
interface seq_game_if #(
  parameter int ADDR_W = 4
);
  logic              iniciar;
  logic              jogada;
  logic              igual;
  logic              modo_timeout;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] limite;
  logic              led_on;
  logic              registra;
  logic              zera_jogada;
  logic [2:0]        vidas;
  logic              acertou;
  logic              errou;
  logic              timeout_flag;
  logic              pronto;
  logic [3:0]        db_estado;

  modport master (
    input  iniciar, jogada, igual, modo_timeout,
    output addr, limite, led_on, registra, zera_jogada, vidas,
           acertou, errou, timeout_flag, pronto, db_estado
  );

  modport slave (
    output iniciar, jogada, igual, modo_timeout,
    input  addr, limite, led_on, registra, zera_jogada, vidas,
           acertou, errou, timeout_flag, pronto, db_estado
  );
endinterface

// File: rtl/seq_game_controller.sv
// Control unit for the memory-sequence game: shows a growing sequence, collects plays,
// tracks rounds, lives and an optional per-play timeout.
module seq_game_controller #(
  parameter int ADDR_W    = 4,
  parameter int N_ROUNDS  = 16,
  parameter int T_SHOW    = 1000,
  parameter int T_GAP     = 250,
  parameter int T_TIMEOUT = 3000,
  parameter int LIVES     = 3
) (
  input  logic       clock,
  input  logic       reset,
  seq_game_if.master bus
);

  localparam int TMR_MAX0 = (T_SHOW > T_GAP) ? T_SHOW : T_GAP;
  localparam int TMR_MAX  = (TMR_MAX0 > T_TIMEOUT) ? TMR_MAX0 : T_TIMEOUT;
  localparam int TMR_W    = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0]  SHOW_LAST  = TMR_W'(T_SHOW - 1);
  localparam logic [TMR_W-1:0]  GAP_LAST   = TMR_W'(T_GAP - 1);
  localparam logic [TMR_W-1:0]  TO_LAST    = TMR_W'(T_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LAST_ROUND = ADDR_W'(N_ROUNDS - 1);
  localparam logic [2:0]        LIVES_INIT = 3'(LIVES);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    INIT       = 4'd1,
    NEW_ROUND  = 4'd2,
    SHOW_ON    = 4'd3,
    SHOW_OFF   = 4'd4,
    PLAY_START = 4'd5,
    WAIT       = 4'd6,
    REGISTER   = 4'd7,
    COMPARE    = 4'd8,
    NEXT       = 4'd9,
    ROUND_DONE = 4'd10,
    LOSE_LIFE  = 4'd11,
    WIN        = 4'd12,
    LOSE       = 4'd13
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] e;
  logic [ADDR_W-1:0] l;
  logic [TMR_W-1:0]  timer;
  logic [2:0]        vidas;
  logic              tflag;
  logic              led_r;
  logic              registra_r;
  logic              zera_r;
  logic              acertou_r;
  logic              errou_r;
  logic              pronto_r;

  logic show_end;
  logic gap_end;
  logic wait_expire;

  assign show_end    = (timer == SHOW_LAST);
  assign gap_end     = (timer == GAP_LAST);
  assign wait_expire = bus.modo_timeout && (timer == TO_LAST);

  // An error either costs a life and replays the round, or ends the game.
  function automatic state_t error_dest(input logic [2:0] lives_left);
    return (lives_left > 3'd1) ? LOSE_LIFE : LOSE;
  endfunction

  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:       state_n = bus.iniciar ? INIT : IDLE;
      INIT:       state_n = NEW_ROUND;
      NEW_ROUND:  state_n = SHOW_ON;
      SHOW_ON:    state_n = show_end ? SHOW_OFF : SHOW_ON;
      SHOW_OFF: begin
        if (!gap_end)    state_n = SHOW_OFF;
        else if (e == l) state_n = PLAY_START;
        else             state_n = SHOW_ON;
      end
      PLAY_START: state_n = WAIT;
      WAIT: begin
        if (bus.jogada)       state_n = REGISTER;
        else if (wait_expire) state_n = error_dest(vidas);
        else                  state_n = WAIT;
      end
      REGISTER:   state_n = COMPARE;
      COMPARE: begin
        if (!bus.igual)  state_n = error_dest(vidas);
        else if (e == l) state_n = ROUND_DONE;
        else             state_n = NEXT;
      end
      NEXT:       state_n = WAIT;
      ROUND_DONE: state_n = (l == LAST_ROUND) ? WIN : NEW_ROUND;
      LOSE_LIFE:  state_n = NEW_ROUND;
      WIN:        state_n = bus.iniciar ? INIT : WIN;
      LOSE:       state_n = bus.iniciar ? INIT : LOSE;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      e          <= '0;
      l          <= '0;
      timer      <= '0;
      vidas      <= '0;
      tflag      <= 1'b0;
      led_r      <= 1'b0;
      registra_r <= 1'b0;
      zera_r     <= 1'b0;
      acertou_r  <= 1'b0;
      errou_r    <= 1'b0;
      pronto_r   <= 1'b0;
    end else begin
      state      <= state_n;
      led_r      <= (state_n == SHOW_ON);
      registra_r <= (state_n == REGISTER);
      zera_r     <= (state_n == INIT) || (state_n == PLAY_START);
      acertou_r  <= (state_n == WIN);
      errou_r    <= (state_n == LOSE);
      pronto_r   <= (state_n == WIN) || (state_n == LOSE);

      case (state)
        NEW_ROUND, PLAY_START: begin
          e     <= '0;
          timer <= '0;
        end
        SHOW_ON: begin
          if (show_end) timer <= '0;
          else          timer <= timer + 1'b1;
        end
        SHOW_OFF: begin
          if (gap_end) begin
            timer <= '0;
            if (e != l) e <= e + 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT: begin
          // The timer parks at its last value when the timeout is disabled.
          if (!bus.jogada) begin
            if (wait_expire) begin
              if (vidas <= 3'd1) begin
                vidas <= '0;
                tflag <= 1'b1;
              end
            end else if (timer != TO_LAST) begin
              timer <= timer + 1'b1;
            end
          end
        end
        COMPARE: begin
          if (!bus.igual && (vidas <= 3'd1)) vidas <= '0;
        end
        NEXT: begin
          e     <= e + 1'b1;
          timer <= '0;
        end
        ROUND_DONE: begin
          if (l != LAST_ROUND) l <= l + 1'b1;
        end
        LOSE_LIFE: vidas <= vidas - 1'b1;
        default: ;
      endcase

      // Entering INIT is a full restart, visible while INIT is shown.
      if (state_n == INIT) begin
        e     <= '0;
        l     <= '0;
        timer <= '0;
        vidas <= LIVES_INIT;
        tflag <= 1'b0;
      end
    end
  end

  assign bus.addr         = e;
  assign bus.limite       = l;
  assign bus.led_on       = led_r;
  assign bus.registra     = registra_r;
  assign bus.zera_jogada  = zera_r;
  assign bus.vidas        = vidas;
  assign bus.acertou      = acertou_r;
  assign bus.errou        = errou_r;
  assign bus.timeout_flag = tflag;
  assign bus.pronto       = pronto_r;
  assign bus.db_estado    = state;

endmodule

// File: tb/tb_seq_game_controller.sv
// Randomized self-checking bench for seq_game_controller; a game-level model tracks
// round, position and lives and predicts each visible outcome.
module tb_seq_game_controller;

  localparam int ADDR_W    = 2;
  localparam int N_ROUNDS  = 4;
  localparam int T_SHOW    = 4;
  localparam int T_GAP     = 2;
  localparam int T_TIMEOUT = 5;
  localparam int LIVES     = 3;

  localparam int ACT_OK   = 0;
  localparam int ACT_BAD  = 1;
  localparam int ACT_TOUT = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  seq_game_if #(.ADDR_W(ADDR_W)) bus ();

  seq_game_controller #(
    .ADDR_W(ADDR_W), .N_ROUNDS(N_ROUNDS), .T_SHOW(T_SHOW),
    .T_GAP(T_GAP), .T_TIMEOUT(T_TIMEOUT), .LIVES(LIVES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int act;
    int d;
    bit modo;
  } step_t;
  step_t script[$];

  // Game-level model state.
  int rnd;
  int pos;
  int lives;
  int g_done;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_chk++;
    if (obs !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic show_phase();
    int cnt;
    cnt = 0;
    while (!bus.led_on && cnt < 30) begin tick(); cnt++; end
    chk("show_start", bus.led_on, 1);
    chk("limite_show", bus.limite, rnd);
    chk("vidas_show", bus.vidas, lives);
    for (int k = 0; k <= rnd; k++) begin
      chk("addr_show", bus.addr, k);
      cnt = 0;
      while (bus.led_on && cnt < 50) begin tick(); cnt++; end
      chk("show_len", cnt, T_SHOW);
      cnt = 0;
      if (k < rnd) begin
        while (!bus.led_on && cnt < 50) begin tick(); cnt++; end
        chk("gap_len", cnt, T_GAP);
      end else begin
        while (bus.db_estado != 4'd6 && cnt < 50) begin tick(); cnt++; end
        chk("gap_to_wait", cnt, T_GAP + 1);
      end
    end
  endtask

  task automatic on_error(input bit by_timeout);
    lives--;
    if (lives == 0) begin
      chk("lose_state", bus.db_estado, 13);
      chk("lose_errou", bus.errou, 1);
      chk("lose_pronto", bus.pronto, 1);
      chk("lose_acertou", bus.acertou, 0);
      chk("lose_tflag", bus.timeout_flag, by_timeout);
      chk("lose_vidas", bus.vidas, 0);
      g_done = 2;
    end else begin
      chk("life_state", bus.db_estado, 11);
      chk("life_limite", bus.limite, rnd);
      tick();
      chk("replay_state", bus.db_estado, 2);
      chk("replay_vidas", bus.vidas, lives);
      pos = 0;
    end
  endtask

  task automatic play_pos(input int act, input int d, input bit modo);
    int cnt;
    chk("wait_state", bus.db_estado, 6);
    chk("addr_wait", bus.addr, pos);
    if (act == ACT_TOUT) begin
      bus.modo_timeout = 1'b1;
      cnt = 0;
      while (bus.db_estado == 4'd6 && cnt < 50) begin tick(); cnt++; end
      chk("timeout_len", cnt, T_TIMEOUT);
      bus.modo_timeout = 1'b0;
      on_error(1'b1);
    end else begin
      bus.modo_timeout = modo;
      bus.igual = (act == ACT_OK);
      repeat (d) tick();
      chk("still_wait", bus.db_estado, 6);
      bus.jogada = 1'b1;
      tick();
      bus.jogada = 1'b0;
      chk("reg_state", bus.db_estado, 7);
      chk("registra", bus.registra, 1);
      tick();
      chk("cmp_state", bus.db_estado, 8);
      chk("registra_off", bus.registra, 0);
      tick();
      bus.modo_timeout = 1'b0;
      if (act == ACT_BAD) begin
        on_error(1'b0);
      end else if (pos == rnd) begin
        chk("rdone_state", bus.db_estado, 10);
        tick();
        if (rnd == N_ROUNDS - 1) begin
          chk("win_state", bus.db_estado, 12);
          chk("win_acertou", bus.acertou, 1);
          chk("win_pronto", bus.pronto, 1);
          chk("win_errou", bus.errou, 0);
          chk("win_limite", bus.limite, N_ROUNDS - 1);
          g_done = 1;
        end else begin
          rnd++;
          pos = 0;
          chk("newround_state", bus.db_estado, 2);
          chk("newround_limite", bus.limite, rnd);
        end
      end else begin
        chk("next_state", bus.db_estado, 9);
        tick();
        pos++;
      end
    end
  endtask

  task automatic start_game();
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    chk("init_state", bus.db_estado, 1);
    chk("init_vidas", bus.vidas, LIVES);
    chk("init_tflag", bus.timeout_flag, 0);
    chk("init_errou", bus.errou, 0);
    chk("init_pronto", bus.pronto, 0);
    chk("init_zera", bus.zera_jogada, 1);
    rnd = 0;
    pos = 0;
    lives = LIVES;
    g_done = 0;
  endtask

  task automatic run_game();
    int guard;
    int r;
    step_t s;
    start_game();
    guard = 0;
    while (g_done == 0 && guard < 200) begin
      guard++;
      if (pos == 0) show_phase();
      if (script.size() > 0) begin
        s = script.pop_front();
      end else begin
        r = $urandom_range(0, 99);
        s.act  = (r < 80) ? ACT_OK : (r < 90) ? ACT_BAD : ACT_TOUT;
        s.modo = 1'($urandom_range(0, 1));
        s.d    = s.modo ? $urandom_range(0, T_TIMEOUT - 1) : $urandom_range(0, 12);
      end
      play_pos(s.act, s.d, s.modo);
    end
    chk("game_ended", (g_done != 0) ? 1 : 0, 1);
  endtask

  task automatic push_step(input int act, input int d, input bit modo);
    step_t s;
    s.act = act;
    s.d = d;
    s.modo = modo;
    script.push_back(s);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset = 1'b1;
    bus.iniciar = 1'b0;
    bus.jogada = 1'b0;
    bus.igual = 1'b0;
    bus.modo_timeout = 1'b0;
    tick();
    tick();
    chk("rst_state", bus.db_estado, 0);
    chk("rst_addr", bus.addr, 0);
    chk("rst_limite", bus.limite, 0);
    chk("rst_vidas", bus.vidas, 0);
    chk("rst_flags", {bus.led_on, bus.registra, bus.zera_jogada, bus.acertou,
                      bus.errou, bus.timeout_flag, bus.pronto}, 0);
    reset = 1'b0;
    tick();
    tick();
    chk("idle_hold", bus.db_estado, 0);

    // Wait-forever, timeout, lost life, timeout/play tie, then final loss by timeout.
    push_step(ACT_OK, 100, 1'b0);
    push_step(ACT_TOUT, 0, 1'b1);
    push_step(ACT_BAD, 2, 1'b0);
    push_step(ACT_OK, T_TIMEOUT - 1, 1'b1);
    push_step(ACT_TOUT, 0, 1'b1);
    run_game();
    chk("dir1_lost", g_done, 2);

    // Three wrong plays in round 0: loss not caused by timeout.
    push_step(ACT_BAD, 0, 1'b0);
    push_step(ACT_BAD, 1, 1'b1);
    push_step(ACT_BAD, 3, 1'b0);
    run_game();
    chk("dir2_lost", g_done, 2);

    // All-correct game through the last round.
    for (int i = 0; i < N_ROUNDS * (N_ROUNDS + 1) / 2; i++)
      push_step(ACT_OK, $urandom_range(0, T_TIMEOUT - 1), 1'($urandom_range(0, 1)));
    run_game();
    chk("dir3_won", g_done, 1);

    for (int g = 0; g < 8; g++) run_game();

    // Reset in the middle of round 1's display.
    start_game();
    show_phase();
    play_pos(ACT_OK, 1, 1'b0);
    begin
      int cnt;
      cnt = 0;
      while (!bus.led_on && cnt < 30) begin tick(); cnt++; end
    end
    tick();
    chk("pre_rst_show", bus.db_estado, 3);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_state", bus.db_estado, 0);
    chk("async_rst_led", bus.led_on, 0);
    tick();
    chk("mid_rst_state", bus.db_estado, 0);
    chk("mid_rst_addr", bus.addr, 0);
    chk("mid_rst_limite", bus.limite, 0);
    chk("mid_rst_led", bus.led_on, 0);
    chk("mid_rst_vidas", bus.vidas, 0);
    chk("mid_rst_pronto", {bus.pronto, bus.acertou}, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_idle", bus.db_estado, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
